// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO: synchronises in_port, latches edges into a W1C register and raises a
// maskable level irq. Define AVALON_PIO_IN_DEBOUNCE_EN to add per-bit debounce counters.
module avalon_pio_in_edge #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE     = WIDTH'(4'hF),
   parameter int unsigned      DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecapture_q, edgecapture_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [WIDTH-1:0] val, rise, fall, edge_det, clr;
   logic             wr_en, rd_en;

`ifdef AVALON_PIO_IN_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0] deb_q, deb_d;
   logic [CntW-1:0]  cnt_q [WIDTH];
   logic [CntW-1:0]  cnt_d [WIDTH];

   // A bit only follows sync2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q <= RESET_VALUE;
         cnt_q <= '{default: '0};
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign val = deb_q;
`else
   logic unused_debounce_cfg;
   assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
   assign val = sync2_q;
`endif

   always_comb begin
      rise  = val & ~prev_q;
      fall  = ~val & prev_q;
      case (EDGE_TYPE)
         0:       edge_det = rise;
         1:       edge_det = fall;
         default: edge_det = rise | fall;
      endcase

      wr_en = chipselect & ~write_n;
      rd_en = chipselect & ~read_n;

      irqmask_d = irqmask_q;
      if (wr_en && address == 3'd2) irqmask_d = writedata[WIDTH-1:0];

      // A new edge overrides a simultaneous clear of the same bit.
      clr           = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
      edgecapture_d = (edgecapture_q & ~clr) | edge_det;

      readdata_d = readdata_q;
      if (rd_en) begin
         case (address)
            3'd0:    readdata_d = 32'(val);
            3'd2:    readdata_d = 32'(irqmask_q);
            3'd3:    readdata_d = 32'(edgecapture_q);
            default: readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q       <= RESET_VALUE;
         sync2_q       <= RESET_VALUE;
         prev_q        <= RESET_VALUE;
         irqmask_q     <= '0;
         edgecapture_q <= '0;
         readdata_q    <= '0;
      end else begin
         sync1_q       <= in_port;
         sync2_q       <= sync1_q;
         prev_q        <= val;
         irqmask_q     <= irqmask_d;
         edgecapture_q <= edgecapture_d;
         readdata_q    <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecapture_q & irqmask_q);

endmodule
